// File: rtl/r88_pairseq_if.sv
// r88_pairseq_if: groups the command handshake from instruction decode and the byte-wide
// regblock access signals of r88_pairseq.
//   cmdValid/cmdReady/cmdOp/cmdPair/cmdOperand : command request and operands
//   busIn/busOut/busOutEn                       : intD read data, write data, drive enable
//   regSel/regRead/regWrite                     : regblock access controls
//   done/result/carryOut                        : completion pulse and held results
// modport slave is the sequencer; modport master is the decode/regblock side.
interface r88_pairseq_if;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [1:0]  cmdPair;
    logic [15:0] cmdOperand;
    logic [7:0]  busIn;
    logic [7:0]  busOut;
    logic        busOutEn;
    logic [3:0]  regSel;
    logic        regRead;
    logic        regWrite;
    logic        done;
    logic [15:0] result;
    logic        carryOut;

    modport slave (
        input  cmdValid, cmdOp, cmdPair, cmdOperand, busIn,
        output cmdReady, busOut, busOutEn, regSel, regRead, regWrite, done, result, carryOut
    );

    modport master (
        output cmdValid, cmdOp, cmdPair, cmdOperand, busIn,
        input  cmdReady, busOut, busOutEn, regSel, regRead, regWrite, done, result, carryOut
    );
endinterface

// File: rtl/r88_pairseq.sv
// r88_pairseq: sequences 16-bit register-pair INC/DEC/ADDS/LOAD16 as byte accesses through
// the regblock's 8-bit port. One command at a time, valid/ready handshake.
//   sysClock  : clock, all state on rising edge
//   sysResetN : asynchronous active-low reset
//   bus       : r88_pairseq_if.slave (command handshake, regblock access, results)
// All regblock-facing outputs are registered and decoded from the next state.
module r88_pairseq #(
    parameter bit         SKIP_HI  = 1'b1,
    parameter logic [3:0] IDLE_SEL = 4'd15
) (
    input logic          sysClock,
    input logic          sysResetN,
    r88_pairseq_if.slave bus
);
    localparam logic [1:0] OpInc    = 2'd0;
    localparam logic [1:0] OpDec    = 2'd1;
    localparam logic [1:0] OpAdds   = 2'd2;
    localparam logic [1:0] OpLoad16 = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StRdLo, StCapLo, StWrLo, StRdHi, StCapHi, StWrHi, StDone
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_op, w_op_next;
    logic [1:0]  r_pair, w_pair_next;
    logic [15:0] r_operand, w_operand_next;
    logic [7:0]  r_lo, w_lo_next;
    logic        r_c, w_c_next;
    logic [7:0]  r_hi, w_hi_next;
    logic        r_cy, w_cy_next;
    logic [3:0]  r_sel, w_sel_next;
    logic        r_rd, w_rd_next;
    logic        r_wr, w_wr_next;
    logic [7:0]  r_bus_out, w_bus_out_next;
    logic        r_done, w_done_next;
    logic [15:0] r_result, w_result_next;
    logic        r_carry_out, w_carry_out_next;

    logic [7:0]  w_add_lo, w_add_ext;
    logic [8:0]  w_lo_sum, w_hi_sum;
    logic [7:0]  w_hi_addend;
    logic        w_skip;
    logic [3:0]  w_lo_sel, w_hi_sel;

    always_comb begin
        w_add_lo  = 8'h00;
        w_add_ext = 8'h00;
        case (r_op)
            OpInc:   begin w_add_lo = 8'h01;           w_add_ext = 8'h00;               end
            OpDec:   begin w_add_lo = 8'hFF;           w_add_ext = 8'hFF;               end
            OpAdds:  begin w_add_lo = r_operand[7:0];  w_add_ext = {8{r_operand[7]}};   end
            default: begin w_add_lo = 8'h00;           w_add_ext = 8'h00;               end
        endcase
    end

    assign w_lo_sum    = {1'b0, bus.busIn} + {1'b0, w_add_lo};
    assign w_hi_sum    = {1'b0, bus.busIn} + {1'b0, w_add_ext} + {8'h00, r_c};
    assign w_hi_addend = w_add_ext + {7'h00, r_c};
    // A zero high addend leaves the high byte unchanged, so its write can be dropped.
    assign w_skip      = SKIP_HI && (w_hi_addend == 8'h00);
    // Select follows the pair being latched this cycle so the first access is not delayed.
    assign w_lo_sel    = 4'd3 + {1'b0, w_pair_next, 1'b0};
    assign w_hi_sel    = w_lo_sel + 4'd1;

    always_comb begin
        w_state_next     = r_state;
        w_op_next        = r_op;
        w_pair_next      = r_pair;
        w_operand_next   = r_operand;
        w_lo_next        = r_lo;
        w_c_next         = r_c;
        w_hi_next        = r_hi;
        w_cy_next        = r_cy;
        w_result_next    = r_result;
        w_carry_out_next = r_carry_out;

        unique case (r_state)
            StIdle: begin
                if (bus.cmdValid) begin
                    w_op_next      = bus.cmdOp;
                    w_pair_next    = bus.cmdPair;
                    w_operand_next = bus.cmdOperand;
                    if (bus.cmdOp == OpLoad16) begin
                        w_lo_next    = bus.cmdOperand[7:0];
                        w_hi_next    = bus.cmdOperand[15:8];
                        w_cy_next    = 1'b0;
                        w_state_next = StWrLo;
                    end else begin
                        w_state_next = StRdLo;
                    end
                end
            end
            StRdLo:  w_state_next = StCapLo;
            StCapLo: begin
                w_lo_next    = w_lo_sum[7:0];
                w_c_next     = w_lo_sum[8];
                w_state_next = StWrLo;
            end
            StWrLo:  w_state_next = (r_op == OpLoad16) ? StWrHi : StRdHi;
            StRdHi:  w_state_next = StCapHi;
            StCapHi: begin
                w_hi_next    = w_hi_sum[7:0];
                w_cy_next    = w_hi_sum[8];
                w_state_next = w_skip ? StDone : StWrHi;
            end
            StWrHi:  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        if ((w_state_next == StDone) && (r_state != StDone)) begin
            w_result_next    = {w_hi_next, w_lo_next};
            w_carry_out_next = w_cy_next;
        end
    end

    // Registered regblock controls decoded from the state being entered.
    always_comb begin
        w_sel_next     = IDLE_SEL;
        w_rd_next      = 1'b0;
        w_wr_next      = 1'b0;
        w_bus_out_next = 8'h00;
        w_done_next    = 1'b0;
        unique case (w_state_next)
            StRdLo, StCapLo: begin w_rd_next = 1'b1; w_sel_next = w_lo_sel; end
            StRdHi, StCapHi: begin w_rd_next = 1'b1; w_sel_next = w_hi_sel; end
            StWrLo: begin
                w_wr_next      = 1'b1;
                w_sel_next     = w_lo_sel;
                w_bus_out_next = w_lo_next;
            end
            StWrHi: begin
                w_wr_next      = 1'b1;
                w_sel_next     = w_hi_sel;
                w_bus_out_next = w_hi_next;
            end
            StDone:  w_done_next = 1'b1;
            default: w_done_next = 1'b0;
        endcase
    end

    always_ff @(posedge sysClock or negedge sysResetN) begin
        if (!sysResetN) begin
            r_state     <= StIdle;
            r_op        <= 2'd0;
            r_pair      <= 2'd0;
            r_operand   <= 16'h0000;
            r_lo        <= 8'h00;
            r_c         <= 1'b0;
            r_hi        <= 8'h00;
            r_cy        <= 1'b0;
            r_sel       <= IDLE_SEL;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_bus_out   <= 8'h00;
            r_done      <= 1'b0;
            r_result    <= 16'h0000;
            r_carry_out <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_pair      <= w_pair_next;
            r_operand   <= w_operand_next;
            r_lo        <= w_lo_next;
            r_c         <= w_c_next;
            r_hi        <= w_hi_next;
            r_cy        <= w_cy_next;
            r_sel       <= w_sel_next;
            r_rd        <= w_rd_next;
            r_wr        <= w_wr_next;
            r_bus_out   <= w_bus_out_next;
            r_done      <= w_done_next;
            r_result    <= w_result_next;
            r_carry_out <= w_carry_out_next;
        end
    end

    assign bus.cmdReady = (r_state == StIdle);
    assign bus.busOut   = r_bus_out;
    assign bus.busOutEn = r_wr;
    assign bus.regSel   = r_sel;
    assign bus.regRead  = r_rd;
    assign bus.regWrite = r_wr;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.carryOut = r_carry_out;
endmodule

// File: tb/tb_r88_pairseq.sv
// tb_r88_pairseq: randomized and directed bench for r88_pairseq against a 16-bit arithmetic
// reference model, with a behavioural byte regblock on the DUT's register port.
module tb_r88_pairseq;
    localparam bit         Skip    = 1'b1;
    localparam logic [3:0] IdleSel = 4'd15;

    logic sysClock  = 1'b0;
    logic sysResetN = 1'b0;

    r88_pairseq_if bus_if ();

    r88_pairseq #(
        .SKIP_HI  (Skip),
        .IDLE_SEL (IdleSel)
    ) dut (
        .sysClock  (sysClock),
        .sysResetN (sysResetN),
        .bus       (bus_if.slave)
    );

    always #5 sysClock = ~sysClock;

    // Byte regblock: read data appears the cycle after regRead is sampled.
    logic [7:0] mem [16];
    logic       pre_en  = 1'b0;
    logic [3:0] pre_idx = 4'd0;
    logic [7:0] pre_val = 8'h00;

    always @(posedge sysClock) begin
        if (bus_if.regRead)  bus_if.busIn <= mem[bus_if.regSel];
        if (bus_if.regWrite) mem[bus_if.regSel] <= bus_if.busOut;
        if (pre_en)          mem[pre_idx] <= pre_val;
    end

    // Reference model: architectural 16-bit pair values.
    logic [15:0] ref_pair [4];

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int busy_rdy = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge sysClock) begin
        if (sysResetN) begin
            if (bus_if.regRead && bus_if.regWrite) viol++;
            if (!bus_if.regRead && !bus_if.regWrite && bus_if.regSel != IdleSel) viol++;
            if (bus_if.busOutEn != bus_if.regWrite) viol++;
        end
    end

    function automatic logic [3:0] lo_sel(input logic [1:0] p);
        return 4'd3 + 4'(p) * 4'd2;
    endfunction

    task automatic preset(input logic [1:0] p, input logic [15:0] val);
        ref_pair[p] = val;
        pre_en = 1'b1; pre_idx = lo_sel(p); pre_val = val[7:0];
        @(posedge sysClock); #1;
        pre_idx = lo_sel(p) + 4'd1; pre_val = val[15:8];
        @(posedge sysClock); #1;
        pre_en = 1'b0;
        @(negedge sysClock);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] p, input logic [15:0] opnd,
                           input bit noise);
        logic [15:0] old, add16, exp_val;
        logic [16:0] sum17;
        logic [7:0]  hi_add;
        logic        exp_cy, skip, hiwr;
        int          exp_lat, lat, w;

        old   = ref_pair[p];
        add16 = (op == 2'd0) ? 16'h0001 : (op == 2'd1) ? 16'hFFFF : {{8{opnd[7]}}, opnd[7:0]};
        sum17 = {1'b0, old} + {1'b0, add16};
        if (op == 2'd3) begin
            exp_val = opnd; exp_cy = 1'b0; exp_lat = 3; skip = 1'b0;
        end else begin
            exp_val = sum17[15:0];
            exp_cy  = sum17[16];
            hi_add  = add16[15:8] + 8'((({1'b0, old[7:0]} + {1'b0, add16[7:0]}) >> 8));
            skip    = Skip && (hi_add == 8'h00);
            exp_lat = skip ? 6 : 7;
        end

        bus_if.cmdValid = 1'b1; bus_if.cmdOp = op; bus_if.cmdPair = p; bus_if.cmdOperand = opnd;
        w = 0;
        while (!bus_if.cmdReady && w < 10) begin @(negedge sysClock); w++; end
        if (!bus_if.cmdReady) begin
            check_eq("accept_timeout", 0, 1);
            bus_if.cmdValid = 1'b0;
            return;
        end
        @(posedge sysClock); #1;
        bus_if.cmdValid = noise ? 1'($urandom) : 1'b0;

        lat = 0; hiwr = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge sysClock);
            if (bus_if.cmdReady) busy_rdy++;
            if (bus_if.regWrite && bus_if.regSel == lo_sel(p) + 4'd1) hiwr = 1'b1;
            if (bus_if.done) begin lat = n; break; end
            if (noise) begin
                bus_if.cmdValid   = 1'($urandom);
                bus_if.cmdOp      = 2'($urandom);
                bus_if.cmdPair    = 2'($urandom);
                bus_if.cmdOperand = 16'($urandom);
            end
        end
        bus_if.cmdValid = 1'b0;

        ref_pair[p] = exp_val;
        check_eq("latency", lat, exp_lat);
        check_eq("result", bus_if.result, exp_val);
        check_eq("carryOut", bus_if.carryOut, exp_cy);
        check_eq("hi_write", hiwr, !skip);
        check_eq("pair_mem", {mem[lo_sel(p) + 4'd1], mem[lo_sel(p)]}, exp_val);
    endtask

    logic [15:0] edge_vals [6];

    initial begin
        bus_if.cmdValid = 1'b0; bus_if.cmdOp = 2'd0; bus_if.cmdPair = 2'd0;
        bus_if.cmdOperand = 16'h0000;
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF; edge_vals[2] = 16'h00FF;
        edge_vals[3] = 16'hFF00; edge_vals[4] = 16'h7FFF; edge_vals[5] = 16'h8000;

        repeat (3) @(negedge sysClock);
        check_eq("rst_regSel", bus_if.regSel, IdleSel);
        check_eq("rst_rw", {bus_if.regRead, bus_if.regWrite, bus_if.busOutEn}, 0);
        check_eq("rst_done", bus_if.done, 0);
        check_eq("rst_busOut", bus_if.busOut, 0);
        check_eq("rst_result", {bus_if.carryOut, bus_if.result}, 0);
        check_eq("rst_ready", bus_if.cmdReady, 1);
        sysResetN = 1'b1;
        @(negedge sysClock);
        for (int i = 0; i < 4; i++) preset(2'(i), 16'($urandom));

        // Directed cases
        preset(2'd2, 16'h12FF); run_cmd(2'd0, 2'd2, 16'h0000, 1'b0);
        preset(2'd3, 16'h0010); run_cmd(2'd0, 2'd3, 16'h0000, 1'b0);
        preset(2'd0, 16'h0000); run_cmd(2'd1, 2'd0, 16'h0000, 1'b0);
        preset(2'd1, 16'h1005); run_cmd(2'd2, 2'd1, 16'h00FA, 1'b0);
        preset(2'd1, 16'hFFFF); run_cmd(2'd2, 2'd1, 16'h0002, 1'b0);
        preset(2'd3, 16'hFFFF); run_cmd(2'd0, 2'd3, 16'h0000, 1'b0);
        run_cmd(2'd3, 2'd3, 16'hBEEF, 1'b1);

        // Randomized, with back-to-back issue and busy-time noise on cmd*
        for (int i = 0; i < 80; i++) begin
            logic [1:0] p;
            p = 2'($urandom);
            if ($urandom_range(0, 3) == 0) preset(p, edge_vals[$urandom_range(0, 5)]);
            run_cmd(2'($urandom), p, 16'($urandom), 1'($urandom));
        end

        // Reset in CAP_HI: lo byte already written, hi untouched
        @(negedge sysClock);
        preset(2'd3, 16'h12FF);
        bus_if.cmdValid = 1'b1; bus_if.cmdOp = 2'd0; bus_if.cmdPair = 2'd3;
        @(posedge sysClock); #1;
        bus_if.cmdValid = 1'b0;
        repeat (5) @(negedge sysClock);
        check_eq("caphi_state", {bus_if.regRead, bus_if.regSel}, {1'b1, 4'd10});
        sysResetN = 1'b0;
        #1;
        check_eq("midrst_regSel", bus_if.regSel, IdleSel);
        check_eq("midrst_rw", {bus_if.regRead, bus_if.regWrite, bus_if.busOutEn}, 0);
        check_eq("midrst_out", {bus_if.done, bus_if.busOut}, 0);
        check_eq("midrst_result", {bus_if.carryOut, bus_if.result}, 0);
        repeat (2) @(negedge sysClock);
        sysResetN = 1'b1;
        ref_pair[3] = 16'h1200;
        check_eq("midrst_pair", {mem[10], mem[9]}, 16'h1200);
        @(negedge sysClock);

        for (int i = 0; i < 10; i++) run_cmd(2'($urandom), 2'($urandom), 16'($urandom), 1'b1);

        for (int i = 0; i < 4; i++)
            check_eq("final_pair", {mem[lo_sel(2'(i)) + 4'd1], mem[lo_sel(2'(i))]}, ref_pair[i]);
        check_eq("protocol_viol", viol, 0);
        check_eq("busy_ready", busy_rdy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
